// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle RV32I core: Moore FSM that steps one
// instruction through fetch/decode/execute/memory/writeback, plus ALU and immediate decoders.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_JAL       = 4'd9,
    S_BEQ       = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw, done_raw, illegal_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        // Speculatively form old_pc + imm so branches/jumps find their target in alu_out.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_READ: begin
        state_d = S_MEM_WB;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_EXEC_R: begin
        state_d   = S_ALU_WB;
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        state_d   = S_ALU_WB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_JAL: begin
        // Writes old_pc + 4 as the link value while PC takes the target from alu_out.
        state_d   = S_ALU_WB;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        done_raw  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Strobes are gated with rst_n so nothing writes during or at the instant of reset.
  assign pc_write   = (pc_update | (branch & zero)) & rst_n;
  assign ir_write   = ir_write_raw  & rst_n;
  assign mem_write  = mem_write_raw & rst_n;
  assign reg_write  = reg_write_raw & rst_n;
  assign instr_done = done_raw      & rst_n;
  assign illegal    = illegal_raw   & rst_n;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its
// state sequence and checks strobes/selects against hand-computed values.
module tb_multicycle_control;
  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_mem_write", mem_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("fetch_state", state, 0);
    check("fetch_ir_write", ir_write, 1);
    check("fetch_pc_write", pc_write, 1);
    check("fetch_alu_src_b", alu_src_b, 2'b10);
    check("fetch_result_src", result_src, 2'b10);
    check("fetch_alu_control", alu_control, 0);

    // lw: 0,1,2,3,4,0
    opcode = 7'b0000011;
    #1;
    check("lw_fetch_done", instr_done, 0);
    tick();
    check("lw_s1", state, 1);
    check("lw_dec_src_a", alu_src_a, 2'b01);
    check("lw_dec_imm", imm_src, 2'b00);
    check("lw_dec_reg_write", reg_write, 0);
    tick();
    check("lw_s2", state, 2);
    check("lw_adr_src_a", alu_src_a, 2'b10);
    check("lw_adr_done", instr_done, 0);
    tick();
    check("lw_s3", state, 3);
    check("lw_read_adr_src", adr_src, 1);
    check("lw_read_reg_write", reg_write, 0);
    check("lw_read_done", instr_done, 0);
    tick();
    check("lw_s4", state, 4);
    check("lw_wb_reg_write", reg_write, 1);
    check("lw_wb_result_src", result_src, 2'b01);
    check("lw_wb_done", instr_done, 1);
    tick();
    check("lw_back_fetch", state, 0);
    check("lw_fetch_done2", instr_done, 0);

    // R-type: funct decode inside EXEC_R
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick();
    check("r_s1", state, 1);
    tick();
    check("r_s6", state, 6);
    check("r_sub", alu_control, 3'b001);
    check("r_src_b", alu_src_b, 2'b00);
    funct7_5 = 1'b0; #1;
    check("r_add", alu_control, 3'b000);
    funct3 = 3'b111; #1;
    check("r_and", alu_control, 3'b010);
    funct3 = 3'b010; #1;
    check("r_slt", alu_control, 3'b101);
    tick();
    check("r_s7", state, 7);
    check("r_wb_reg_write", reg_write, 1);
    check("r_wb_done", instr_done, 1);
    funct3 = 3'b110; tick();
    check("r_back_fetch", state, 0);

    // I-type: funct7_5 must not turn addi into sub
    opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick();
    tick();
    check("i_s8", state, 8);
    check("i_addi", alu_control, 3'b000);
    check("i_src_b", alu_src_b, 2'b01);
    funct3 = 3'b110; #1;
    check("i_or", alu_control, 3'b011);
    tick();
    check("i_s7", state, 7);
    tick();
    check("i_back_fetch", state, 0);

    // beq: zero honoured only in BEQ
    opcode = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b1;
    #1;
    check("beq_imm", imm_src, 2'b10);
    tick();
    check("beq_s1", state, 1);
    check("beq_dec_no_pcw", pc_write, 0);
    tick();
    check("beq_s10", state, 10);
    check("beq_taken_pcw", pc_write, 1);
    check("beq_sub", alu_control, 3'b001);
    check("beq_done", instr_done, 1);
    zero = 1'b0; #1;
    check("beq_not_taken_pcw", pc_write, 0);
    tick();
    check("beq_back_fetch", state, 0);

    // jal: 0,1,9,7,0
    opcode = 7'b1101111;
    #1;
    check("jal_imm", imm_src, 2'b11);
    tick();
    check("jal_s1", state, 1);
    tick();
    check("jal_s9", state, 9);
    check("jal_pcw", pc_write, 1);
    check("jal_src_a", alu_src_a, 2'b01);
    check("jal_reg_write", reg_write, 0);
    tick();
    check("jal_s7", state, 7);
    check("jal_wb_reg_write", reg_write, 1);
    tick();
    check("jal_back_fetch", state, 0);

    // illegal opcode
    opcode = 7'b1111111;
    tick();
    check("ill_s1", state, 1);
    check("ill_pulse", illegal, 1);
    check("ill_imm", imm_src, 2'b00);
    tick();
    check("ill_back_fetch", state, 0);
    check("ill_cleared", illegal, 0);

    // sw, then reset during MEM_WRITE
    opcode = 7'b0100011;
    tick();
    check("sw_s1", state, 1);
    check("sw_imm", imm_src, 2'b01);
    tick();
    check("sw_s2", state, 2);
    tick();
    check("sw_s5", state, 5);
    check("sw_mem_write", mem_write, 1);
    check("sw_adr_src", adr_src, 1);
    check("sw_done", instr_done, 1);
    #1 rst_n = 1'b0;
    #1;
    check("sw_rst_mem_write", mem_write, 0);
    check("sw_rst_state", state, 0);
    check("sw_rst_done", instr_done, 0);
    check("sw_rst_ir_write", ir_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_decode", state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
